mips_instr_encoder: RTL and testbench

//  Inverse of the CPU control decoder: turns a mnemonic code plus register/immediate fields

---
 rtl/mips_isa_pkg.sv | 54 +++++
 rtl/mips_word_pack.sv | 56 +++++
 rtl/mips_instr_encoder.sv | 103 ++++++++++
 tb/tb_mips_instr_encoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: mnemonic codes, opcode/funct values and encoder FSM states.
// Kept common with the control decoder so both sides agree on every encoding.
package mips_isa_pkg;

    typedef enum logic [4:0] {
        MN_ADD  = 5'd0,  MN_SUB  = 5'd1,  MN_AND  = 5'd2,  MN_OR   = 5'd3,
        MN_XOR  = 5'd4,  MN_SLL  = 5'd5,  MN_SRL  = 5'd6,  MN_SRA  = 5'd7,
        MN_JR   = 5'd8,  MN_ADDI = 5'd9,  MN_ANDI = 5'd10, MN_ORI  = 5'd11,
        MN_XORI = 5'd12, MN_LW   = 5'd13, MN_SW   = 5'd14, MN_BEQ  = 5'd15,
        MN_BNE  = 5'd16, MN_LUI  = 5'd17, MN_J    = 5'd18, MN_JAL  = 5'd19,
        MN_NOP  = 5'd20, MN_MOVE = 5'd21, MN_LI   = 5'd22
    } mnem_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_SEND_HI = 2'd2
    } state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_word_pack.sv
// Combinational packer: mnemonic plus operand fields -> one or two instruction words.
// Fields an instruction does not use are zeroed here so junk inputs never leak into the word.
module mips_word_pack
    import mips_isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [31:0] imm,
    output logic [31:0] word0,
    output logic [31:0] word1,
    output logic        two_words,
    output logic        illegal
);

    always_comb begin
        word0     = '0;
        word1     = '0;
        two_words = 1'b0;
        illegal   = 1'b0;
        case (mnem)
            MN_ADD:  word0 = r_word(rs, rt, rd, 5'd0, FN_ADD);
            MN_SUB:  word0 = r_word(rs, rt, rd, 5'd0, FN_SUB);
            MN_AND:  word0 = r_word(rs, rt, rd, 5'd0, FN_AND);
            MN_OR:   word0 = r_word(rs, rt, rd, 5'd0, FN_OR);
            MN_XOR:  word0 = r_word(rs, rt, rd, 5'd0, FN_XOR);
            MN_SLL:  word0 = r_word(5'd0, rt, rd, shamt, FN_SLL);
            MN_SRL:  word0 = r_word(5'd0, rt, rd, shamt, FN_SRL);
            MN_SRA:  word0 = r_word(5'd0, rt, rd, shamt, FN_SRA);
            MN_JR:   word0 = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_ADDI: word0 = i_word(OP_ADDI, rs, rt, imm[15:0]);
            MN_ANDI: word0 = i_word(OP_ANDI, rs, rt, imm[15:0]);
            MN_ORI:  word0 = i_word(OP_ORI,  rs, rt, imm[15:0]);
            MN_XORI: word0 = i_word(OP_XORI, rs, rt, imm[15:0]);
            MN_LW:   word0 = i_word(OP_LW,   rs, rt, imm[15:0]);
            MN_SW:   word0 = i_word(OP_SW,   rs, rt, imm[15:0]);
            MN_BEQ:  word0 = i_word(OP_BEQ,  rs, rt, imm[15:0]);
            MN_BNE:  word0 = i_word(OP_BNE,  rs, rt, imm[15:0]);
            MN_LUI:  word0 = i_word(OP_LUI, 5'd0, rt, imm[15:0]);
            MN_J:    word0 = {OP_J, imm[25:0]};
            MN_JAL:  word0 = {OP_JAL, imm[25:0]};
            MN_NOP:  word0 = '0;
            MN_MOVE: word0 = r_word(rs, 5'd0, rd, 5'd0, FN_ADD);
            // LI splits into LUI of the upper half followed by ORI of the lower half.
            MN_LI: begin
                word0     = i_word(OP_LUI, 5'd0, rt, imm[31:16]);
                word1     = i_word(OP_ORI, rt, rt, imm[15:0]);
                two_words = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Instruction encoder: accepts mnemonic requests and streams encoded words with
// sequential imem addresses; LI produces two words, illegal mnemonics pulse err.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_mnem,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              err
);

    state_e      state;
    logic [31:0] pend_word;
    logic [31:0] pk_word0;
    logic [31:0] pk_word1;
    logic        pk_two_words;
    logic        pk_illegal;
    logic        accept;
    logic        load;

    mips_word_pack u_pack (
        .mnem      (req_mnem),
        .rs        (req_rs),
        .rt        (req_rt),
        .rd        (req_rd),
        .shamt     (req_shamt),
        .imm       (req_imm),
        .word0     (pk_word0),
        .word1     (pk_word1),
        .two_words (pk_two_words),
        .illegal   (pk_illegal)
    );

    // A new request can only enter when the output slot is empty or draining this cycle.
    always_comb begin
        req_ready = 1'b0;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_SEND: req_ready = out_ready;
            default: req_ready = 1'b0;
        endcase
    end

    assign accept = req_valid & req_ready;
    assign load   = accept & ~pk_illegal;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            out_addr  <= ADDR_W'(BASE_ADDR);
            pend_word <= '0;
        end else begin
            err <= accept & pk_illegal;
            if (out_valid && out_ready)
                out_addr <= out_addr + ADDR_W'(1);
            if (load) begin
                out_word  <= pk_word0;
                out_valid <= 1'b1;
                out_last  <= ~pk_two_words;
                pend_word <= pk_word1;
                state     <= pk_two_words ? ST_SEND_HI : ST_SEND;
            end else begin
                case (state)
                    ST_SEND: if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= ST_IDLE;
                    end
                    ST_SEND_HI: if (out_ready) begin
                        out_word <= pend_word;
                        out_last <= 1'b1;
                        state    <= ST_SEND;
                    end
                    ST_IDLE: ;
                    default: begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed self-checking bench for mips_instr_encoder (default instance plus a
// small-address instance for wrap and mid-LI reset).
module tb_mips_instr_encoder;

    logic        clock;
    logic        reset;
    logic [4:0]  req_mnem, req_rs, req_rt, req_rd, req_shamt;
    logic [31:0] req_imm;

    logic        req_valid, req_ready, out_valid, out_ready, out_last, err;
    logic [31:0] out_word;
    logic [5:0]  out_addr;

    logic        req_valid_b, req_ready_b, out_valid_b, out_ready_b, out_last_b, err_b;
    logic [31:0] out_word_b;
    logic [3:0]  out_addr_b;

    int passed;
    int total;

    mips_instr_encoder dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mnem(req_mnem),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
        .req_imm(req_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr), .out_last(out_last), .err(err)
    );

    mips_instr_encoder #(.ADDR_W(4), .BASE_ADDR(14)) dut_b (
        .clock(clock), .reset(reset),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_mnem(req_mnem),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
        .req_imm(req_imm), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_word(out_word_b), .out_addr(out_addr_b), .out_last(out_last_b), .err(err_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm);
        req_mnem  = m;
        req_rs    = rs;
        req_rt    = rt;
        req_rd    = rd;
        req_shamt = sh;
        req_imm   = imm;
    endtask

    task automatic do_reset();
        req_valid   = 1'b0;
        req_valid_b = 1'b0;
        out_ready   = 1'b0;
        out_ready_b = 1'b0;
        reset       = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step();
        total++;
        if ({out_valid, out_last, err, out_word, out_addr, req_ready} !== {3'b000, 32'h0, 6'd0, 1'b1})
            $display("[TB] FAIL reset_state: got v=%b l=%b e=%b w=%h a=%0d rr=%b, want 0 0 0 00000000 0 1",
                     out_valid, out_last, err, out_word, out_addr, req_ready);
        else passed++;
        total++;
        if ({out_valid_b, out_addr_b} !== {1'b0, 4'd14})
            $display("[TB] FAIL reset_base_addr: got v=%b a=%0d, want v=0 a=14", out_valid_b, out_addr_b);
        else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_add();
        do_reset();
        set_req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        total++;
        if ({out_valid, out_last, out_word, out_addr} !== {2'b11, 32'h00221820, 6'd0})
            $display("[TB] FAIL add_word: got v=%b l=%b w=%h a=%0d, want 1 1 00221820 0",
                     out_valid, out_last, out_word, out_addr);
        else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if ({out_valid, out_addr} !== {1'b0, 6'd1})
            $display("[TB] FAIL add_drain: got v=%b a=%0d, want 0 1", out_valid, out_addr);
        else passed++;
    endtask

    task automatic test_li_stall();
        do_reset();
        set_req(5'd22, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({out_valid, out_last, out_word, out_addr, req_ready} !== {2'b10, 32'h3C081234, 6'd0, 1'b0})
                $display("[TB] FAIL li_hold_%0d: got v=%b l=%b w=%h a=%0d rr=%b, want 1 0 3c081234 0 0",
                         i, out_valid, out_last, out_word, out_addr, req_ready);
            else passed++;
            step();
        end
        out_ready = 1'b1;
        step();
        total++;
        if ({out_valid, out_last, out_word, out_addr, req_ready} !== {2'b11, 32'h35085678, 6'd1, 1'b1})
            $display("[TB] FAIL li_low: got v=%b l=%b w=%h a=%0d rr=%b, want 1 1 35085678 1 1",
                     out_valid, out_last, out_word, out_addr, req_ready);
        else passed++;
        step();
        out_ready = 1'b0;
        total++;
        if ({out_valid, out_addr} !== {1'b0, 6'd2})
            $display("[TB] FAIL li_drain: got v=%b a=%0d, want 0 2", out_valid, out_addr);
        else passed++;
    endtask

    task automatic test_fields();
        logic [4:0]  m   [6] = '{5'd14, 5'd5, 5'd19, 5'd21, 5'd8, 5'd20};
        logic [4:0]  rs  [6] = '{5'd29, 5'd9, 5'd7, 5'd6, 5'd31, 5'd3};
        logic [4:0]  rt  [6] = '{5'd4, 5'd2, 5'd5, 5'd9, 5'd17, 5'd4};
        logic [4:0]  rd  [6] = '{5'd7, 5'd2, 5'd6, 5'd5, 5'd12, 5'd5};
        logic [4:0]  sh  [6] = '{5'd3, 5'd4, 5'd8, 5'd11, 5'd2, 5'd6};
        logic [31:0] imm [6] = '{32'h0000FFFC, 32'hFFFF0000, 32'hFC000040, 32'h0000BEEF,
                                 32'h12345678, 32'hFFFFFFFF};
        logic [31:0] exp [6] = '{32'hAFA4FFFC, 32'h00021100, 32'h0C000040, 32'h00C02820,
                                 32'h03E00008, 32'h00000000};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_req(m[i], rs[i], rt[i], rd[i], sh[i], imm[i]);
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            total++;
            if ({out_valid, out_last, out_word, out_addr} !== {2'b11, exp[i], 6'(i)})
                $display("[TB] FAIL field_%0d: got v=%b l=%b w=%h a=%0d, want 1 1 %h %0d",
                         i, out_valid, out_last, out_word, out_addr, exp[i], i);
            else passed++;
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_word;
        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_req(5'd0, 5'd1, 5'd2, 5'(k), 5'd0, 32'h0);
            req_valid = 1'b1;
            step();
            exp_word = 32'h00220020 | (32'(k) << 11);
            total++;
            if ({out_valid, out_last, out_word, out_addr} !== {2'b11, exp_word, 6'(k - 1)})
                $display("[TB] FAIL b2b_%0d: got v=%b l=%b w=%h a=%0d, want 1 1 %h %0d",
                         k, out_valid, out_last, out_word, out_addr, exp_word, k - 1);
            else passed++;
        end
        req_valid = 1'b0;
        step();
        out_ready = 1'b0;
        total++;
        if ({out_valid, out_addr} !== {1'b0, 6'd4})
            $display("[TB] FAIL b2b_drain: got v=%b a=%0d, want 0 4", out_valid, out_addr);
        else passed++;
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 1'b1;
        set_req(5'd25, 5'd1, 5'd2, 5'd3, 5'd4, 32'h1);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        total++;
        if ({out_valid, err, out_addr} !== {2'b01, 6'd0})
            $display("[TB] FAIL illegal_idle: got v=%b e=%b a=%0d, want 0 1 0", out_valid, err, out_addr);
        else passed++;
        step();
        total++;
        if ({out_valid, err, out_addr} !== {2'b00, 6'd0})
            $display("[TB] FAIL illegal_pulse: got v=%b e=%b a=%0d, want 0 0 0", out_valid, err, out_addr);
        else passed++;
        set_req(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        req_valid = 1'b1;
        step();
        set_req(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        step();
        req_valid = 1'b0;
        total++;
        if ({out_valid, err, out_addr} !== {2'b01, 6'd1})
            $display("[TB] FAIL illegal_send: got v=%b e=%b a=%0d, want 0 1 1", out_valid, err, out_addr);
        else passed++;
        step();
        out_ready = 1'b0;
        total++;
        if (err !== 1'b0)
            $display("[TB] FAIL illegal_send_pulse: got e=%b, want 0", err);
        else passed++;
    endtask

    task automatic test_wrap_and_reset();
        logic [3:0] exp_addr [3] = '{4'd14, 4'd15, 4'd0};
        do_reset();
        out_ready_b = 1'b1;
        set_req(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        req_valid_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({out_valid_b, out_word_b, out_addr_b} !== {1'b1, 32'h0, exp_addr[i]})
                $display("[TB] FAIL wrap_%0d: got v=%b w=%h a=%0d, want 1 00000000 %0d",
                         i, out_valid_b, out_word_b, out_addr_b, exp_addr[i]);
            else passed++;
        end
        req_valid_b = 1'b0;
        step();
        out_ready_b = 1'b0;
        set_req(5'd22, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678);
        req_valid_b = 1'b1;
        step();
        req_valid_b = 1'b0;
        total++;
        if ({out_valid_b, out_last_b, out_word_b, out_addr_b} !== {2'b10, 32'h3C081234, 4'd1})
            $display("[TB] FAIL wrap_li: got v=%b l=%b w=%h a=%0d, want 1 0 3c081234 1",
                     out_valid_b, out_last_b, out_word_b, out_addr_b);
        else passed++;
        #2 reset = 1'b1;
        #1;
        total++;
        if ({out_valid_b, out_addr_b} !== {1'b0, 4'd14})
            $display("[TB] FAIL midli_reset: got v=%b a=%0d, want 0 14", out_valid_b, out_addr_b);
        else passed++;
        step();
        reset = 1'b0;
        out_ready_b = 1'b1;
        step();
        step();
        out_ready_b = 1'b0;
        total++;
        if ({out_valid_b, out_word_b, out_addr_b} !== {1'b0, 32'h0, 4'd14})
            $display("[TB] FAIL midli_dropped: got v=%b w=%h a=%0d, want 0 00000000 14",
                     out_valid_b, out_word_b, out_addr_b);
        else passed++;
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_valid_b = 1'b0;
        out_ready   = 1'b0;
        out_ready_b = 1'b0;
        set_req(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        test_reset();
        test_add();
        test_li_stall();
        test_fields();
        test_back_to_back();
        test_illegal();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
